// File: rtl/audio_pkg.sv
// Shared audio capture/playback definitions.
// Sample widths, record FSM states and mono-mix helpers.
package audio_pkg;

    localparam int AUDIO_SAMPLE_W = 16;
    localparam int AUDIO_ADDR_W   = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_RECORD = 2'd2,
        ST_DONE   = 2'd3
    } rec_state_t;

    // Average of two signed 32-bit channels, no overflow.
    function automatic logic [31:0] mono_mix(
        input logic [31:0] l,
        input logic [31:0] r
    );
        logic [32:0] sum;
        sum = {l[31], l} + {r[31], r};
        return sum[32:1];
    endfunction

    // Magnitude; the most-negative code clamps to max positive.
    function automatic logic [AUDIO_SAMPLE_W-1:0] abs_sat(
        input logic [AUDIO_SAMPLE_W-1:0] s
    );
        logic [AUDIO_SAMPLE_W-1:0] neg;
        neg = ~s + 1'b1;
        if (!s[AUDIO_SAMPLE_W-1]) begin
            return s;
        end else if (neg[AUDIO_SAMPLE_W-1]) begin
            return {1'b0, {(AUDIO_SAMPLE_W-1){1'b1}}};
        end else begin
            return neg;
        end
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write, one registered read.
// Read-before-write on address collision.
module capture_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Storage array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; sees the pre-write word on collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/audio_in_recorder.sv
// Audio-in capture: mono mix, decimation, triggered record to RAM.
// FSM, decimator and mixer live here; storage is capture_ram.
module audio_in_recorder
    import audio_pkg::*;
#(
    parameter int ADDR_W   = AUDIO_ADDR_W,
    parameter int SAMPLE_W = AUDIO_SAMPLE_W,
    parameter logic [SAMPLE_W-1:0] TRIG_LEVEL = 16'd2048
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                audio_in_available,
    input  logic [31:0]         left_channel_audio_in,
    input  logic [31:0]         right_channel_audio_in,
    output logic                read_audio_in,
    input  logic                start,
    input  logic                abort,
    input  logic                trig_en,
    input  logic [3:0]          decim,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     wr_count
);

    localparam logic [ADDR_W:0] FULL  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_W = {{ADDR_W{1'b0}}, 1'b1};

    rec_state_t          state_q;
    logic [3:0]          dcnt_q;
    logic [3:0]          dcnt_d;
    logic [3:0]          decim_q;
    logic [ADDR_W:0]     wr_count_q;
    logic [ADDR_W:0]     wr_count_d;
    logic                done_q;
    logic                busy_q;

    logic                se;
    logic                accept;
    logic [31:0]         mix;
    logic [SAMPLE_W-1:0] sample;
    logic [SAMPLE_W-1:0] mag;
    logic                hit;
    logic                mix_unused;

    logic                we;
    logic [ADDR_W-1:0]   waddr;

    // The codec FIFO is always drained, whatever the state.
    assign read_audio_in = audio_in_available & ~reset;
    assign se            = audio_in_available & read_audio_in;

    assign mix        = mono_mix(left_channel_audio_in,
                                 right_channel_audio_in);
    assign sample     = mix[31 -: SAMPLE_W];
    assign mix_unused = ^mix[31-SAMPLE_W:0];
    assign mag        = abs_sat(sample);
    assign hit        = (mag >= TRIG_LEVEL);

    assign dcnt_d     = (dcnt_q == decim_q) ? 4'd0 : dcnt_q + 4'd1;
    assign accept     = se & (dcnt_q == 4'd0);
    assign wr_count_d = wr_count_q + ONE_W;

    // Select RAM write: trigger sample lands at 0, then sequential.
    always_comb begin
        we    = 1'b0;
        waddr = wr_count_q[ADDR_W-1:0];
        unique case (state_q)
            ST_ARM: begin
                we    = accept & hit & ~abort;
                waddr = '0;
            end
            ST_RECORD: begin
                we = accept & ~abort;
            end
            default: begin
                we = 1'b0;
            end
        endcase
    end

    // Record FSM with decimator and registered status outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dcnt_q     <= 4'd0;
            decim_q    <= 4'd0;
            wr_count_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start && !abort) begin
                        wr_count_q <= '0;
                        done_q     <= 1'b0;
                        decim_q    <= decim;
                        dcnt_q     <= 4'd0;
                        busy_q     <= 1'b1;
                        state_q    <= trig_en ? ST_ARM : ST_RECORD;
                    end
                end
                ST_ARM: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (se) begin
                        if (accept && hit) begin
                            wr_count_q <= ONE_W;
                            dcnt_q     <= 4'd0;
                            state_q    <= ST_RECORD;
                        end else begin
                            dcnt_q <= dcnt_d;
                        end
                    end
                end
                ST_RECORD: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (se) begin
                        dcnt_q <= dcnt_d;
                        if (accept) begin
                            wr_count_q <= wr_count_d;
                            if (wr_count_d == FULL) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_count = wr_count_q;

    capture_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (SAMPLE_W)
    ) u_ram (
        .clk   (CLOCK_50),
        .rst   (reset),
        .we    (we),
        .waddr (waddr),
        .wdata (sample),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_audio_in_recorder.sv
// Self-checking bench for audio_in_recorder.
// Table vectors, hand sequences and random traffic vs a queue-free model.
module tb_audio_in_recorder;

    logic        clk;
    logic        rst;
    logic        av;
    logic [31:0] l_in;
    logic [31:0] r_in;
    logic        rd_strobe;
    logic        st;
    logic        ab;
    logic        tg;
    logic [3:0]  dc;
    logic [9:0]  ra;
    logic [15:0] rdat;
    logic        busy;
    logic        done;
    logic [10:0] wrc;

    int nvec = 0;
    int nmis = 0;

    // Behavioural model: phase 0 idle, 1 waiting trigger, 2 recording, 3 full
    int          m_ph;
    int          m_cnt;
    int          m_k;
    int          m_dec;
    bit          m_done;
    logic [15:0] mram [1024];
    bit          mvalid [1024];
    bit          e_rd_ok;
    logic [15:0] e_rd;

    typedef struct {
        logic        av;
        int          v;
        logic        st;
        logic        ab;
        logic        tg;
        logic [3:0]  dc;
        logic        e_busy;
        logic        e_done;
        logic [10:0] e_wrc;
    } vec_t;

    vec_t tv [6];

    audio_in_recorder dut (
        .CLOCK_50               (clk),
        .reset                  (rst),
        .audio_in_available     (av),
        .left_channel_audio_in  (l_in),
        .right_channel_audio_in (r_in),
        .read_audio_in          (rd_strobe),
        .start                  (st),
        .abort                  (ab),
        .trig_en                (tg),
        .decim                  (dc),
        .rd_addr                (ra),
        .rd_data                (rdat),
        .busy                   (busy),
        .done                   (done),
        .wr_count               (wrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_write(input int a, input logic [15:0] d);
        mram[a]   = d;
        mvalid[a] = 1'b1;
    endtask

    task automatic model_update();
        longint      s;
        longint      smp;
        int          mag;
        logic [15:0] s16;
        bit          acc;
        s   = longint'($signed(l_in)) + longint'($signed(r_in));
        s   = s >>> 1;
        smp = s >>> 16;
        s16 = smp[15:0];
        mag = (smp < 0) ? int'(-smp) : int'(smp);
        if (mag > 32767) mag = 32767;
        if (rst) begin
            m_ph = 0; m_cnt = 0; m_k = 0; m_dec = 0; m_done = 0;
        end else begin
            case (m_ph)
                0, 3: if (st && !ab) begin
                    m_cnt = 0; m_done = 0; m_dec = int'(dc); m_k = 0;
                    m_ph = tg ? 1 : 2;
                end
                1: if (ab) m_ph = 0;
                   else if (av) begin
                    acc = (m_k % (m_dec + 1)) == 0;
                    m_k++;
                    if (acc && mag >= 2048) begin
                        model_write(0, s16);
                        m_cnt = 1; m_k = 0; m_ph = 2;
                    end
                end
                2: if (ab) m_ph = 0;
                   else if (av) begin
                    acc = (m_k % (m_dec + 1)) == 0;
                    m_k++;
                    if (acc) begin
                        model_write(m_cnt, s16);
                        m_cnt++;
                        if (m_cnt == 1024) begin
                            m_ph = 3; m_done = 1;
                        end
                    end
                end
                default: m_ph = 0;
            endcase
        end
    endtask

    // One clock: check strobe, advance model, check registered outputs.
    task automatic tick();
        #1;
        chk("read_audio_in", rd_strobe, av & ~rst);
        if (rst) begin
            e_rd_ok = 1'b1; e_rd = 16'h0;
        end else begin
            e_rd_ok = mvalid[ra]; e_rd = mram[ra];
        end
        model_update();
        @(posedge clk);
        #1;
        chk("busy", busy, (m_ph == 1 || m_ph == 2));
        chk("done", done, m_done);
        chk("wr_count", wrc, m_cnt);
        if (e_rd_ok) chk("rd_data", rdat, e_rd);
        st = 1'b0;
        ab = 1'b0;
        av = 1'b0;
    endtask

    task automatic se_v(input int v);
        logic [15:0] t;
        t    = v[15:0];
        av   = 1'b1;
        l_in = {t, 16'h0};
        r_in = {t, 16'h0};
        tick();
    endtask

    task automatic do_start(input logic trig, input logic [3:0] d);
        st = 1'b1; tg = trig; dc = d;
        tick();
    endtask

    task automatic rd_at(input logic [9:0] a, input logic [15:0] exp, input string nm);
        ra = a;
        tick();
        chk(nm, rdat, exp);
    endtask

    initial begin
        rst = 1'b1; av = 0; l_in = 0; r_in = 0;
        st = 0; ab = 0; tg = 0; dc = 0; ra = 0;
        m_ph = 0; m_cnt = 0; m_k = 0; m_dec = 0; m_done = 0;
        for (int i = 0; i < 1024; i++) begin
            mvalid[i] = 1'b0; mram[i] = 16'h0;
        end
        tv[0] = '{1'b0, 0,    1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 11'd0};
        tv[1] = '{1'b1, 100,  1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 11'd0};
        tv[2] = '{1'b1, 200,  1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 11'd0};
        tv[3] = '{1'b1, 3000, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 11'd1};
        tv[4] = '{1'b1, 10,   1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 11'd2};
        tv[5] = '{1'b0, 0,    1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 11'd2};

        @(negedge clk);
        tick();
        tick();
        chk("reset_rd_data", rdat, 16'h0);
        chk("reset_wr_count", wrc, 11'd0);
        rst = 1'b0;

        // FIFO drained while idle, nothing recorded
        for (int i = 0; i < 5; i++) begin
            se_v(i + 1);
            chk("idle_busy", busy, 1'b0);
            chk("idle_wr_count", wrc, 11'd0);
        end

        // Full untriggered record of a ramp
        do_start(1'b0, 4'd0);
        for (int n = 0; n < 1024; n++) se_v(n);
        chk("full_done", done, 1'b1);
        chk("full_wr_count", wrc, 11'd1024);
        se_v(77);
        chk("full_hold", wrc, 11'd1024);
        rd_at(10'd5, 16'd5, "rd_addr5");
        rd_at(10'd1023, 16'd1023, "rd_addr1023");

        // Level trigger, table-driven
        for (int i = 0; i < 6; i++) begin
            st = tv[i].st; ab = tv[i].ab; tg = tv[i].tg; dc = tv[i].dc;
            if (tv[i].av) begin
                se_v(tv[i].v);
            end else begin
                tick();
            end
            chk($sformatf("tv%0d_busy", i), busy, tv[i].e_busy);
            chk($sformatf("tv%0d_done", i), done, tv[i].e_done);
            chk($sformatf("tv%0d_wrc", i), wrc, tv[i].e_wrc);
        end
        rd_at(10'd0, 16'd3000, "trig_ram0");
        rd_at(10'd1, 16'd10, "trig_ram1");

        // Decimate by 3
        do_start(1'b0, 4'd2);
        for (int n = 0; n < 9; n++) se_v(n);
        chk("decim_wrc", wrc, 11'd3);
        ab = 1'b1; tick();
        rd_at(10'd0, 16'd0, "decim_ram0");
        rd_at(10'd1, 16'd3, "decim_ram1");
        rd_at(10'd2, 16'd6, "decim_ram2");

        // Trigger threshold edges and most-negative saturation
        do_start(1'b1, 4'd0);
        se_v(2047);
        se_v(-2047);
        chk("below_thresh", wrc, 11'd0);
        se_v(-2048);
        chk("at_thresh", wrc, 11'd1);
        ab = 1'b1; tick();
        do_start(1'b1, 4'd0);
        av = 1'b1; l_in = 32'h8000_0000; r_in = 32'h8000_0000;
        tick();
        chk("sat_trig", wrc, 11'd1);
        ab = 1'b1; tick();
        rd_at(10'd0, 16'h8000, "sat_ram0");

        // Abort beats start mid-record
        do_start(1'b0, 4'd0);
        for (int n = 0; n < 7; n++) se_v(100 + n);
        st = 1'b1; ab = 1'b1; tick();
        chk("abort_busy", busy, 1'b0);
        chk("abort_wrc", wrc, 11'd7);
        chk("abort_done", done, 1'b0);
        do_start(1'b0, 4'd0);
        chk("restart_wrc", wrc, 11'd0);
        chk("restart_busy", busy, 1'b1);

        // Reset mid-record keeps RAM, clears count
        se_v(500); se_v(501);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_mid_wrc", wrc, 11'd0);
        rd_at(10'd1, 16'd501, "rst_mid_ram1");

        // Random traffic against the model
        for (int i = 0; i < 6000; i++) begin
            logic [15:0] t;
            int v;
            av = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) != 0) begin
                v = int'($urandom_range(0, 8000)) - 4000;
                t = v[15:0];
                l_in = {t, 16'h0};
                r_in = {t, 16'h0};
            end else begin
                l_in = $urandom;
                r_in = $urandom;
            end
            st  = ($urandom_range(0, 40) == 0);
            ab  = ($urandom_range(0, 400) == 0);
            tg  = $urandom_range(0, 1);
            dc  = 4'($urandom_range(0, 3));
            ra  = 10'($urandom);
            rst = ($urandom_range(0, 1999) == 0);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
